// File: rtl/rom_load_pkg.sv
// Shared types for the ROM download sequencer: FSM states and FIFO entry layout.
package rom_load_pkg;

  localparam int AW_P          = 25;
  localparam int RAW_P         = 16;
  localparam int NREG_P        = 4;
  localparam int FIFO_DEPTH_P  = 4;
  localparam int POST_CYCLES_P = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    HOLD,
    RUN
  } state_e;

  // region is stored already decoded (one-hot) so the pop side drives mem_sel directly
  typedef struct packed {
    logic [NREG_P-1:0] region;
    logic [RAW_P-1:0]  addr;
    logic [7:0]        data;
  } fifo_entry_t;

endpackage

// File: rtl/rom_load_fifo.sv
// Small synchronous FIFO for download bytes; a pop frees the slot a same-cycle push may use.
module rom_load_fifo
  import rom_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  fifo_entry_t din_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [PW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q[PW-1:0]];

  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // storage needs no reset: pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: buffers ioctl bytes into the shared ROM port, arbitrates
// core reads against pending writes, and holds the core in reset until the image is settled.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int AW          = AW_P,
  parameter int RAW         = RAW_P,
  parameter int NREG        = NREG_P,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_P,
  parameter int POST_CYCLES = POST_CYCLES_P
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            dl_active,
  input  logic            dl_wr,
  input  logic [AW-1:0]   dl_addr,
  input  logic [7:0]      dl_data,
  input  logic            rd_req,
  input  logic [RAW-1:0]  rd_addr,
  input  logic [NREG-1:0] rd_region,
  output logic            rd_ack,
  output logic            rd_valid,
  output logic [7:0]      rd_data,
  output logic [NREG-1:0] mem_sel,
  output logic            mem_we,
  output logic [RAW-1:0]  mem_addr,
  output logic [7:0]      mem_din,
  input  logic [7:0]      mem_dout,
  output logic            core_rst,
  output logic            load_done,
  output logic            ovf_err
);

  localparam int            RW     = AW - RAW;
  localparam int            CW     = (POST_CYCLES > 0) ? $clog2(POST_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM   = CW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
  localparam logic [RW-1:0] NREG_W = RW'(NREG);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            core_rst_q, load_done_q, ovf_q;
  logic            we_q, rd_s1_q, rdv_q;
  logic [NREG-1:0] sel_q;
  logic [RAW-1:0]  addr_q;
  logic [7:0]      din_q;

  logic            push, pop, grant, fifo_full, fifo_empty;
  logic [RW-1:0]   dl_reg;
  fifo_entry_t     push_entry, fifo_dout;

  assign dl_reg = dl_addr[AW-1:RAW];
  assign push   = (state_q == LOAD) && dl_wr && (dl_reg < NREG_W);

  // Incoming bytes get the FIFO first; draining happens in gaps between bytes, or when
  // full to make room. Pops are spaced by the write they feed, one write per two cycles.
  assign pop    = !fifo_empty && !we_q && (!push || fifo_full);
  assign grant  = (state_q == RUN) && fifo_empty && rd_req;

  always_comb begin
    push_entry        = '0;
    push_entry.region = NREG'(1) << dl_reg;
    push_entry.addr   = dl_addr[RAW-1:0];
    push_entry.data   = dl_data;
  end

  rom_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // load FSM with settle counter, core reset/done and sticky overflow flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (dl_active) begin
                 state_q <= LOAD;
                 ovf_q   <= 1'b0;
               end
        LOAD:  if (!dl_active) state_q <= DRAIN;
        // an empty FIFO means nothing is popped; the last registered write lands on this edge
        DRAIN: if (fifo_empty) begin
                 state_q <= HOLD;
                 cnt_q   <= '0;
               end
        HOLD:  if (cnt_q == TERM) begin
                 state_q     <= RUN;
                 core_rst_q  <= 1'b0;
                 load_done_q <= 1'b1;
               end else begin
                 cnt_q <= cnt_q + 1'b1;
               end
        RUN:   if (dl_active) begin
                 state_q     <= LOAD;
                 core_rst_q  <= 1'b1;
                 load_done_q <= 1'b0;
                 ovf_q       <= 1'b0;
               end
        default: state_q <= IDLE;
      endcase
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  // ROM port: FIFO write wins, otherwise a granted read; idle cycles deselect all regions
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_s1_q <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      rd_s1_q <= grant;
      rdv_q   <= rd_s1_q;
      if (pop) begin
        we_q   <= 1'b1;
        sel_q  <= fifo_dout.region;
        addr_q <= fifo_dout.addr;
        din_q  <= fifo_dout.data;
      end else if (grant) begin
        sel_q  <= rd_region;
        addr_q <= rd_addr;
      end
    end
  end

  assign rd_ack    = grant;
  assign rd_valid  = rdv_q;
  assign rd_data   = mem_dout;
  assign mem_sel   = sel_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign core_rst  = core_rst_q;
  assign load_done = load_done_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer with a behavioural ROM and a write log.
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [3:0]  rd_region;
  logic        rd_ack, rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  mem_sel;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;
  logic        core_rst, load_done, ovf_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;

  logic [3:0]  log_sel  [$];
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic [7:0]  ram [4][65536];

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_region (rd_region),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .core_rst  (core_rst),
    .load_done (load_done),
    .ovf_err   (ovf_err)
  );

  // behavioural ROM BRAMs, one-cycle read latency
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    for (int r = 0; r < 4; r++) begin
      if (mem_sel[r]) begin
        if (mem_we) ram[r][mem_addr] <= mem_din;
        mem_dout <= ram[r][mem_addr];
      end
    end
  end

  // log every write seen on the port
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      log_sel.push_back(mem_sel);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_din);
      last_we_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int base, found, rel, acks;
    reset_n = 1'b1; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
    rd_req = 0; rd_addr = '0; rd_region = '0;

    // reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_ack", rd_ack, 0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // 1: 16 bytes into region 0, one per 4 clocks
    tick(); dl_active = 1;
    tick();
    @(negedge clk_sys);
    chk("t1_load_core_rst", core_rst, 1);
    tick();
    base = log_sel.size();
    for (int i = 0; i < 16; i++) begin
      dl_wr = 1; dl_addr = 25'(i); dl_data = 8'(8'hA0 + i);
      tick();
      dl_wr = 0;
      if (i == 15) dl_active = 0;
      else repeat (3) tick();
    end
    found = 0; rel = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk_sys);
      if (core_rst == 1'b0) begin found = 1; rel = cyc; end
    end
    chk("t1_release_seen", found, 1);
    // last write cycle W, DRAIN->HOLD at W, 256 HOLD cycles, core released at W+257
    chk("t1_hold_len", rel - last_we_cyc, 257);
    chk("t1_load_done", load_done, 1);
    chk("t1_nwrites", log_sel.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_sel", log_sel[base+i], 4'b0001);
      chk("t1_addr", log_addr[base+i], i);
      chk("t1_data", log_data[base+i], 8'hA0 + i);
    end

    // 4: single read of region 0 addr 5 (0xA5), then 3 back-to-back reads
    tick(); rd_req = 1; rd_addr = 16'd5; rd_region = 4'b0001;
    @(negedge clk_sys);
    chk("t4_ack_N", rd_ack, 1);
    tick(); rd_req = 0;
    @(negedge clk_sys);
    chk("t4_sel_N1", mem_sel, 4'b0001);
    chk("t4_addr_N1", mem_addr, 5);
    chk("t4_we_N1", mem_we, 0);
    chk("t4_valid_N1", rd_valid, 0);
    tick();
    @(negedge clk_sys);
    chk("t4_valid_N2", rd_valid, 1);
    chk("t4_data_N2", rd_data, 8'hA5);
    tick();
    @(negedge clk_sys);
    chk("t4_valid_N3", rd_valid, 0);
    for (int j = 0; j < 5; j++) begin
      tick(); rd_req = (j < 3); rd_addr = 16'(j);
      @(negedge clk_sys);
      if (j < 3) chk("t4_b2b_ack", rd_ack, 1);
      if (j >= 2) begin
        chk("t4_b2b_valid", rd_valid, 1);
        chk("t4_b2b_data", rd_data, 8'hA0 + j - 2);
      end
    end
    tick(); rd_req = 0;
    @(negedge clk_sys);
    chk("t4_b2b_end", rd_valid, 0);

    // 5: read held in RUN while a new download starts
    tick(); rd_req = 1; rd_addr = 16'd7; rd_region = 4'b0001; dl_active = 1;
    @(negedge clk_sys);
    chk("t5_ack_in_run", rd_ack, 1);
    chk("t5_done_before", load_done, 1);
    tick();
    @(negedge clk_sys);
    chk("t5_core_rst", core_rst, 1);
    chk("t5_load_done", load_done, 0);
    chk("t5_ack_load", rd_ack, 0);

    // 3: out-of-range region dropped, region 3 accepted
    tick();
    base = log_sel.size();
    dl_wr = 1; dl_addr = 25'h40000; dl_data = 8'h77;
    tick();
    dl_addr = 25'h30009; dl_data = 8'h3C;
    tick(); dl_wr = 0;
    repeat (4) tick();
    chk("t3_nwrites", log_sel.size() - base, 1);
    chk("t3_sel", log_sel[base], 4'b1000);
    chk("t3_addr", log_addr[base], 16'h0009);
    chk("t3_data", log_data[base], 8'h3C);
    @(negedge clk_sys);
    chk("t3_ovf", ovf_err, 0);
    chk("t3_ack", rd_ack, 0);

    // 2: six consecutive bytes into a 4-deep FIFO
    tick();
    base = log_sel.size();
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1; dl_addr = 25'(25'h10010 + i); dl_data = 8'(8'h60 + i);
      tick();
    end
    dl_wr = 0;
    @(negedge clk_sys);
    chk("t2_ovf", ovf_err, 1);
    repeat (12) tick();
    chk("t2_nwrites", log_sel.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_sel", log_sel[base+i], 4'b0010);
      chk("t2_addr", log_addr[base+i], 16'h0010 + i);
      chk("t2_data", log_data[base+i], 8'h60 + i);
    end

    // finish load; held read must stay unacknowledged until RUN
    dl_active = 0;
    found = 0; acks = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk_sys);
      if (load_done == 1'b1) found = 1;
      else acks += int'(rd_ack);
    end
    chk("t5_run_seen", found, 1);
    chk("t5_no_early_ack", acks, 0);
    chk("t5_ack_in_new_run", rd_ack, 1);
    chk("t2_ovf_sticky", ovf_err, 1);
    chk("t5_core_rst_run", core_rst, 0);

    // 6: async reset mid-LOAD with 3 queued bytes
    tick(); rd_req = 0; dl_active = 1;
    tick();
    @(negedge clk_sys);
    chk("t6_ovf_cleared", ovf_err, 0);
    chk("t6_core_rst", core_rst, 1);
    tick();
    base = log_sel.size();
    for (int i = 0; i < 3; i++) begin
      dl_wr = 1; dl_addr = 25'(25'h20 + i); dl_data = 8'(8'h50 + i);
      tick();
    end
    dl_wr = 0; dl_active = 0; reset_n = 1'b0;
    #1;
    chk("t6_no_write_yet", log_sel.size() - base, 0);
    chk("t6_core_rst_async", core_rst, 1);
    chk("t6_done_async", load_done, 0);
    chk("t6_we_async", mem_we, 0);
    chk("t6_sel_async", mem_sel, 0);
    chk("t6_ovf_async", ovf_err, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_write_after", log_sel.size() - base, 0);
    chk("t6_core_rst_after", core_rst, 1);
    chk("t6_done_after", load_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
